// File: rtl/lbdr_dr_pkg.sv
// lbdr_dr_pkg: flit codes, port/state enums and config struct for the LBDR routing unit
package lbdr_pkg;
  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b100;
  localparam int ADDR_MAX = 16;
  typedef enum logic [1:0] {N = 2'd0, E = 2'd1, W = 2'd2, S = 2'd3} port_e;
  typedef enum logic {IDLE, BUSY} state_e;
  typedef struct packed {
    logic [7:0]          rxy;
    logic [3:0]          cx;
    logic [ADDR_MAX-1:0] cur_addr;
    logic [7:0]          dr;
  } cfg_t;
endpackage

// File: rtl/lbdr_dr_if.sv
// lbdr_dr_if: config, flit and port-select bundle of one LBDR router input port
interface lbdr_dr_if #(parameter int X_W = 2, parameter int Y_W = 2);
  logic               cfg_we;
  logic [7:0]         cfg_rxy;
  logic [3:0]         cfg_cx;
  logic [X_W+Y_W-1:0] cfg_cur_addr;
  logic [7:0]         cfg_dr;
  logic               valid;
  logic [2:0]         flit_id;
  logic [X_W+Y_W-1:0] dst_addr;
  logic               Nport, Eport, Wport, Sport, Lport;
  logic               busy, err_proto, err_unroute;
  modport master (output cfg_we, cfg_rxy, cfg_cx, cfg_cur_addr, cfg_dr, valid, flit_id, dst_addr,
                  input Nport, Eport, Wport, Sport, Lport, busy, err_proto, err_unroute);
  modport slave  (input cfg_we, cfg_rxy, cfg_cx, cfg_cur_addr, cfg_dr, valid, flit_id, dst_addr,
                  output Nport, Eport, Wport, Sport, Lport, busy, err_proto, err_unroute);
endinterface

// File: rtl/lbdr_dr_route_calc.sv
// lbdr_route_calc: combinational LBDR minimal routing with optional deroute fallback (LBDR_DEROUTE_EN)
module lbdr_route_calc
  import lbdr_pkg::*;
#(
  parameter int X_W = 2,
  parameter int Y_W = 2
) (
  input  cfg_t               cfg,
  input  logic [X_W+Y_W-1:0] dst_addr,
  output logic [4:0]         ports,
  output logic               unroute
);
  logic [X_W-1:0] x_d, x_c;
  logic [Y_W-1:0] y_d, y_c;
  logic n1, e1, w1, s1, loc, der;
  logic [3:0] mn, dsel;
  assign x_d = dst_addr[X_W-1:0];
  assign y_d = dst_addr[X_W+Y_W-1:X_W];
  assign x_c = cfg.cur_addr[X_W-1:0];
  assign y_c = cfg.cur_addr[X_W+Y_W-1:X_W];
  assign n1 = y_d < y_c;
  assign s1 = y_c < y_d;
  assign e1 = x_c < x_d;
  assign w1 = x_d < x_c;
  // upper config address bits are always zero, so full-width equality is the local test
  assign loc = ADDR_MAX'(dst_addr) == cfg.cur_addr;
  assign mn[N] = ((n1 & ~e1 & ~w1) | (n1 & e1 & cfg.rxy[0]) | (n1 & w1 & cfg.rxy[1])) & cfg.cx[0];
  assign mn[E] = ((e1 & ~n1 & ~s1) | (e1 & n1 & cfg.rxy[2]) | (e1 & s1 & cfg.rxy[3])) & cfg.cx[1];
  assign mn[W] = ((w1 & ~n1 & ~s1) | (w1 & n1 & cfg.rxy[4]) | (w1 & s1 & cfg.rxy[5])) & cfg.cx[2];
  assign mn[S] = ((s1 & ~e1 & ~w1) | (s1 & e1 & cfg.rxy[6]) | (s1 & w1 & cfg.rxy[7])) & cfg.cx[3];
`ifdef LBDR_DEROUTE_EN
  port_e      prim;
  logic [1:0] dp;
  assign prim = n1 ? N : e1 ? E : w1 ? W : S;
  assign dp   = cfg.dr[{prim, 1'b0} +: 2];
  assign der  = cfg.cx[dp];
  assign dsel = 4'b0001 << dp;
`else
  logic unused_dr;
  assign unused_dr = ^cfg.dr;
  assign der  = 1'b0;
  assign dsel = 4'b0000;
`endif
  assign ports   = loc ? 5'b10000 : |mn ? {1'b0, mn} : der ? {1'b0, dsel} : 5'b00000;
  assign unroute = ~loc & ~|mn & ~der;
endmodule

// File: rtl/lbdr_dr.sv
// lbdr_dr: per-input-port LBDR router with packet FSM and shadow config; LBDR_DEROUTE_EN enables deroute fallback
module lbdr_dr
  import lbdr_pkg::*;
#(
  parameter int          X_W          = 2,
  parameter int          Y_W          = 2,
  parameter logic [7:0]  RXY_RST      = 8'd60,
  parameter logic [3:0]  CX_RST       = 4'd15,
  parameter int          CUR_ADDR_RST = 5,
  parameter logic [7:0]  DR_RST       = 8'd0
) (
  input logic       clk,
  input logic       rst,
  lbdr_dr_if.slave  bus
);
  localparam cfg_t CFG_RST = '{rxy: RXY_RST, cx: CX_RST, cur_addr: ADDR_MAX'(CUR_ADDR_RST), dr: DR_RST};
  state_e     state;
  cfg_t       shadow, active, cfg_sel;
  logic [4:0] ports, calc_ports;
  logic       unroute, err_proto, err_unroute, hdr, pay, tl;
  assign hdr = bus.valid && bus.flit_id == HEADER;
  assign pay = bus.valid && bus.flit_id == PAYLOAD;
  assign tl  = bus.valid && bus.flit_id == TAIL;
  // a header in IDLE routes with the freshly loaded shadow; a re-route in BUSY keeps the packet's config
  assign cfg_sel = state == IDLE ? shadow : active;
  lbdr_route_calc #(.X_W(X_W), .Y_W(Y_W)) u_calc (
    .cfg(cfg_sel), .dst_addr(bus.dst_addr), .ports(calc_ports), .unroute(unroute)
  );
  // packet FSM, shadow config load and error flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      ports       <= '0;
      err_proto   <= 1'b0;
      err_unroute <= 1'b0;
      shadow      <= CFG_RST;
      active      <= CFG_RST;
    end else begin
      err_unroute <= 1'b0;
      if (bus.cfg_we) shadow <= '{rxy: bus.cfg_rxy, cx: bus.cfg_cx, cur_addr: ADDR_MAX'(bus.cfg_cur_addr), dr: bus.cfg_dr};
      if (state == IDLE) begin
        if (hdr) begin
          active      <= shadow;
          ports       <= calc_ports;
          err_unroute <= unroute;
          state       <= unroute ? IDLE : BUSY;
        end else if (pay || tl) err_proto <= 1'b1;
      end else begin
        if (hdr) begin
          err_proto   <= 1'b1;
          ports       <= calc_ports;
          err_unroute <= unroute;
        end else if (tl) begin
          ports <= '0;
          state <= IDLE;
        end
      end
    end
  assign bus.Nport       = ports[N];
  assign bus.Eport       = ports[E];
  assign bus.Wport       = ports[W];
  assign bus.Sport       = ports[S];
  assign bus.Lport       = ports[4];
  assign bus.busy        = state == BUSY;
  assign bus.err_proto   = err_proto;
  assign bus.err_unroute = err_unroute;
endmodule

// File: tb/tb_lbdr_dr.sv
// tb_lbdr_dr: scoreboard bench for lbdr_dr; expectations follow LBDR_DEROUTE_EN when defined
module tb_lbdr_dr;
  import lbdr_pkg::*;
  typedef struct {string nm; logic [7:0] v;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vecs = 0;
  int   errs = 0;
  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  lbdr_dr_if #(.X_W(2), .Y_W(2)) bus ();
  lbdr_dr dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  // expected/observed word: {L,S,W,E,N,busy,err_proto,err_unroute}
  function automatic logic [7:0] mk(input logic [4:0] p, input logic b, input logic ep, input logic eu);
    return {p, b, ep, eu};
  endfunction
  function automatic logic [7:0] outs();
    return {bus.Lport, bus.Sport, bus.Wport, bus.Eport, bus.Nport, bus.busy, bus.err_proto, bus.err_unroute};
  endfunction
  task automatic apply(input logic v, input logic [2:0] id, input logic [3:0] dst, input logic [7:0] ev, input string nm);
    @(negedge clk);
    bus.valid = v; bus.flit_id = id; bus.dst_addr = dst;
    exp_q.push_back('{nm, ev});
    @(posedge clk);
    #1 obs_q.push_back(outs());
  endtask
  task automatic do_reset();
    @(negedge clk);
    bus.valid = 1'b0; bus.cfg_we = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
  endtask
  task automatic test_reset();
    exp_t e; logic [7:0] o;
    bus.valid = 1'b0; bus.flit_id = '0; bus.dst_addr = '0; bus.cfg_we = 1'b0;
    bus.cfg_rxy = '0; bus.cfg_cx = '0; bus.cfg_cur_addr = '0; bus.cfg_dr = '0;
    #1 exp_q.push_back('{"reset", mk(5'b00000, 0, 0, 0)});
    obs_q.push_back(outs());
    @(negedge clk) rst = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e.v) begin errs++; $display("FAIL %s: got %b want %b", e.nm, o, e.v); end
    end
  endtask
  task automatic test_route();
    exp_t e; logic [7:0] o;
    do_reset();
    apply(1, HEADER,  4'd6, mk(5'b00010, 1, 0, 0), "hdr_dst6_E");
    apply(1, PAYLOAD, 4'd0, mk(5'b00010, 1, 0, 0), "pay_hold_E");
    apply(0, PAYLOAD, 4'd0, mk(5'b00010, 1, 0, 0), "idle_hold_E");
    apply(1, TAIL,    4'd0, mk(5'b00000, 0, 0, 0), "tail_clear_E");
    apply(1, HEADER,  4'd0, mk(5'b00100, 1, 0, 0), "hdr_dst0_W");
    apply(1, TAIL,    4'd0, mk(5'b00000, 0, 0, 0), "tail_clear_W");
    apply(1, HEADER,  4'd5, mk(5'b10000, 1, 0, 0), "hdr_dst5_L");
    apply(1, TAIL,    4'd0, mk(5'b00000, 0, 0, 0), "tail_clear_L");
    apply(1, HEADER,  4'd10, mk(5'b00010, 1, 0, 0), "hdr_dst10_SE_E");
    apply(1, TAIL,    4'd0, mk(5'b00000, 0, 0, 0), "tail_clear_SE");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e.v) begin errs++; $display("FAIL %s: got %b want %b", e.nm, o, e.v); end
    end
  endtask
  task automatic test_back_to_back();
    exp_t e; logic [7:0] o;
    do_reset();
    apply(1, HEADER, 4'd9, mk(5'b01000, 1, 0, 0), "b2b_hdr_S");
    apply(1, TAIL,   4'd0, mk(5'b00000, 0, 0, 0), "b2b_tail_S");
    apply(1, HEADER, 4'd1, mk(5'b00001, 1, 0, 0), "b2b_hdr_N");
    apply(1, TAIL,   4'd0, mk(5'b00000, 0, 0, 0), "b2b_tail_N");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e.v) begin errs++; $display("FAIL %s: got %b want %b", e.nm, o, e.v); end
    end
  endtask
  task automatic test_cfg_busy();
    exp_t e; logic [7:0] o;
    do_reset();
    apply(1, HEADER, 4'd6, mk(5'b00010, 1, 0, 0), "cfg_hdr_E");
    bus.cfg_rxy = 8'd60; bus.cfg_cx = 4'b1101; bus.cfg_cur_addr = 4'd5; bus.cfg_dr = 8'h00; bus.cfg_we = 1'b1;
    apply(1, PAYLOAD, 4'd0, mk(5'b00010, 1, 0, 0), "cfg_write_busy_hold");
    bus.cfg_we = 1'b0;
    apply(1, TAIL, 4'd0, mk(5'b00000, 0, 0, 0), "cfg_tail");
`ifdef LBDR_DEROUTE_EN
    apply(1, HEADER, 4'd6, mk(5'b00001, 1, 0, 0), "cfg_deroute_N");
    apply(0, HEADER, 4'd0, mk(5'b00001, 1, 0, 0), "cfg_deroute_hold");
`else
    apply(1, HEADER, 4'd6, mk(5'b00000, 0, 0, 1), "cfg_unroute_pulse");
    apply(0, HEADER, 4'd0, mk(5'b00000, 0, 0, 0), "cfg_unroute_end");
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e.v) begin errs++; $display("FAIL %s: got %b want %b", e.nm, o, e.v); end
    end
  endtask
  task automatic test_missing_tail();
    exp_t e; logic [7:0] o;
    do_reset();
    apply(1, HEADER,  4'd6, mk(5'b00010, 1, 0, 0), "mt_hdr1_E");
    apply(1, HEADER,  4'd0, mk(5'b00100, 1, 1, 0), "mt_hdr2_W");
    apply(1, PAYLOAD, 4'd0, mk(5'b00100, 1, 1, 0), "mt_pay_W");
    apply(1, TAIL,    4'd0, mk(5'b00000, 0, 1, 0), "mt_tail");
    apply(0, TAIL,    4'd0, mk(5'b00000, 0, 1, 0), "mt_sticky");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e.v) begin errs++; $display("FAIL %s: got %b want %b", e.nm, o, e.v); end
    end
  endtask
  task automatic test_tail_idle();
    exp_t e; logic [7:0] o;
    do_reset();
    apply(0, TAIL,    4'd6, mk(5'b00000, 0, 0, 0), "ti_quiet");
    apply(1, TAIL,    4'd6, mk(5'b00000, 0, 1, 0), "ti_tail_idle");
    apply(1, PAYLOAD, 4'd6, mk(5'b00000, 0, 1, 0), "ti_pay_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e.v) begin errs++; $display("FAIL %s: got %b want %b", e.nm, o, e.v); end
    end
  endtask
  task automatic test_reset_mid();
    exp_t e; logic [7:0] o;
    do_reset();
    apply(1, HEADER,  4'd6, mk(5'b00010, 1, 0, 0), "rm_hdr_E");
    apply(1, PAYLOAD, 4'd0, mk(5'b00010, 1, 0, 0), "rm_pay_E");
    #2 rst = 1'b0;
    exp_q.push_back('{"rm_async_clear", mk(5'b00000, 0, 0, 0)});
    #1 obs_q.push_back(outs());
    @(negedge clk) rst = 1'b1;
    apply(1, TAIL, 4'd0, mk(5'b00000, 0, 1, 0), "rm_tail_after");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e.v) begin errs++; $display("FAIL %s: got %b want %b", e.nm, o, e.v); end
    end
  endtask
  initial begin
    test_reset();
    test_route();
    test_back_to_back();
    test_cfg_busy();
    test_missing_tail();
    test_tail_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
